pwm_deserializer: RTL and testbench

Receive-side counterpart of `PWMSerializer`. It samples an asynchronous PWM input (period 2^WIDTH clocks) and recovers the WIDTH-bit duty cycle by counting high samples over a fixed window. The result is presented to the wrapper's memory-mapped IO read mux with a sticky valid/acknowledge handshake. The audio/LED path writes duty values out; this block reads them back in, for loopback self-test and for external PWM sources.

---
 rtl/pwm_deserializer_pkg.sv | 27 ++
 rtl/sync_ff.sv | 24 ++
 rtl/pwm_deserializer.sv | 88 ++++++++
 tb/tb_pwm_deserializer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_deserializer_pkg.sv
// Shared IO definitions for the PWM write path and the PWM read-back block.
// Holds the common duty width, the IO address map and the read-word layout.
package pwm_deserializer_pkg;

    localparam int PWM_WIDTH = 10;

    localparam logic [31:0] IO_SWITCH_ADDR   = 32'd4096;
    localparam logic [31:0] IO_PWM_WR_ADDR   = 32'd4097;
    localparam logic [31:0] IO_PWM_RD_ADDR   = 32'd4098;

    // Read word returned at IO_PWM_RD_ADDR: {overrun, active, duty_valid, duty_cycle}, zero-extended.
    function automatic logic [31:0] io_read_word(
        input logic                 ovr,
        input logic                 act,
        input logic                 val,
        input logic [PWM_WIDTH-1:0] duty
    );
        logic [31:0] word;
        word = '0;
        word[PWM_WIDTH-1:0] = duty;
        word[PWM_WIDTH]     = val;
        word[PWM_WIDTH+1]   = act;
        word[PWM_WIDTH+2]   = ovr;
        return word;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous input.
// Reused for pwm_in and the ps2_clk/ps2_data pins.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pwm_deserializer.sv
// Recovers the duty cycle of a period-2^WIDTH PWM input by counting high
// samples over a free-running 2^WIDTH-cycle window.
module pwm_deserializer
    import pwm_deserializer_pkg::*;
#(
    parameter int WIDTH       = PWM_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    input  logic             enable,
    input  logic             rd_ack,
    output logic [WIDTH-1:0] duty_cycle,
    output logic             duty_valid,
    output logic             overrun,
    output logic             active
);

    logic             s;
    logic             s_prev;
    logic             rise;
    logic [WIDTH-1:0] win;
    logic [WIDTH:0]   hc;
    logic [WIDTH:0]   hc_total;
    logic             rf;
    logic             win_end;
    logic [WIDTH-1:0] duty_next;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (pwm_in),
        .q    (s)
    );

    assign rise     = s & ~s_prev;
    assign win_end  = enable && (win == {WIDTH{1'b1}});
    assign hc_total = hc + {{WIDTH{1'b0}}, s};
    // Only a window high on every sample reaches 2^WIDTH; clamp it to full scale.
    assign duty_next = hc_total[WIDTH] ? {WIDTH{1'b1}} : hc_total[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            s_prev <= 1'b0;
            win    <= '0;
            hc     <= '0;
            rf     <= 1'b0;
        end else begin
            s_prev <= s;
            if (!enable) begin
                win <= '0;
                hc  <= '0;
                rf  <= 1'b0;
            end else if (win_end) begin
                win <= win + 1'b1;
                hc  <= '0;
                rf  <= 1'b0;
            end else begin
                win <= win + 1'b1;
                if (s)    hc <= hc + 1'b1;
                if (rise) rf <= 1'b1;
            end
        end
    end

    // Handshake: duty_valid rises with each result and stays up until a one-cycle
    // rd_ack; an ack coinciding with a window end loses to the new result.
    always_ff @(posedge clk) begin
        if (reset) begin
            duty_cycle <= '0;
            duty_valid <= 1'b0;
            overrun    <= 1'b0;
            active     <= 1'b0;
        end else if (win_end) begin
            duty_cycle <= duty_next;
            active     <= rf | rise;
            duty_valid <= 1'b1;
            overrun    <= overrun | (duty_valid & ~rd_ack);
        end else if (rd_ack) begin
            duty_valid <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_deserializer.sv
// Directed scoreboard bench for pwm_deserializer: a PWM source model feeds the
// DUT, expected results are queued per window and checked at each window end.
module tb_pwm_deserializer;
    import pwm_deserializer_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pwm_in = 1'b0;
    logic       enable = 1'b0;
    logic       rd_ack = 1'b0;
    logic [9:0] duty_cycle;
    logic       duty_valid;
    logic       overrun;
    logic       active;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [31:0] exp_q[$];

    // PWM source: 0 = constant low, 1 = constant high, 2 = PWM at src_duty
    int         src_mode = 0;
    int         src_duty = 0;
    logic [9:0] pcnt = '0;

    // Reference window position, derived from reset/enable alone
    logic [9:0] ref_win = '0;
    logic       wend = 1'b0;

    pwm_deserializer dut (
        .clk       (clk),
        .reset     (reset),
        .pwm_in    (pwm_in),
        .enable    (enable),
        .rd_ack    (rd_ack),
        .duty_cycle(duty_cycle),
        .duty_valid(duty_valid),
        .overrun   (overrun),
        .active    (active)
    );

    // clock / reset-independent timing block
    always #10 clk = ~clk;

    always @(posedge clk) begin
        wend = !reset && enable && (ref_win == 10'd1023);
        if (reset || !enable) ref_win = '0;
        else                  ref_win = ref_win + 10'd1;
    end

    always @(negedge clk) begin
        pcnt = pcnt + 10'd1;
        case (src_mode)
            0:       pwm_in = 1'b0;
            1:       pwm_in = 1'b1;
            default: pwm_in = (int'(pcnt) < src_duty);
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // scoreboard monitor: one expected entry is consumed per window end
    always @(negedge clk) begin
        logic [31:0] e;
        if (wend && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("win_duty",    int'(duty_cycle), int'(e[9:0]));
            check("win_valid",   int'(duty_valid), int'(e[10]));
            check("win_active",  int'(active),     int'(e[11]));
            check("win_overrun", int'(overrun),    int'(e[12]));
        end
    end

    // driver tasks
    task automatic expect_win(input int duty, input bit val, input bit act, input bit ovr);
        exp_q.push_back(io_read_word(ovr, act, val, duty[9:0]));
    endtask

    task automatic wait_win(input int v);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (int'(ref_win) != v && n < 2100);
        if (int'(ref_win) != v) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_win: window position %0d, expected %0d", ref_win, v);
        end
    endtask

    task automatic ack_pulse();
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_duty"},    int'(duty_cycle), 0);
        check({tag, "_valid"},   int'(duty_valid), 0);
        check({tag, "_overrun"}, int'(overrun),    0);
        check({tag, "_active"},  int'(active),     0);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // loopback at duty 300: first window discarded, second exact
        src_mode = 2;
        src_duty = 300;
        enable   = 1'b1;
        wait_win(0);
        ack_pulse();
        check("ack1_valid",   int'(duty_valid), 0);
        check("ack1_overrun", int'(overrun),    0);
        expect_win(300, 1, 1, 0);
        wait_win(0);

        // overrun after a second unread window, then a single ack clears it
        expect_win(300, 1, 1, 1);
        wait_win(0);
        ack_pulse();
        check("ack2_valid",   int'(duty_valid), 0);
        check("ack2_overrun", int'(overrun),    0);
        check("ack2_duty",    int'(duty_cycle), 300);
        expect_win(300, 1, 1, 0);
        wait_win(0);

        // switch to duty 500; ack landing on a window end
        src_duty = 500;
        ack_pulse();
        wait_win(0);
        wait_win(1023);
        rd_ack = 1'b1;
        expect_win(500, 1, 1, 0);
        @(negedge clk);
        rd_ack = 1'b0;
        expect_win(500, 1, 1, 1);
        wait_win(0);
        wait_win(1023);
        rd_ack = 1'b1;
        expect_win(500, 1, 1, 1);
        @(negedge clk);
        rd_ack = 1'b0;

        // constant high saturates, no rising edge in the window
        src_mode = 1;
        ack_pulse();
        wait_win(0);
        ack_pulse();
        expect_win(1023, 1, 0, 0);
        wait_win(0);

        // constant low
        src_mode = 0;
        ack_pulse();
        wait_win(0);
        ack_pulse();
        expect_win(0, 1, 0, 0);
        wait_win(0);

        // duty 700, then reset in the middle of a window
        src_mode = 2;
        src_duty = 700;
        ack_pulse();
        wait_win(0);
        ack_pulse();
        expect_win(700, 1, 1, 0);
        wait_win(0);
        wait_win(500);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        reset = 1'b0;
        wait_win(1023);
        check("postreset_early_valid", int'(duty_valid), 0);
        @(negedge clk);
        check("postreset_valid", int'(duty_valid), 1);
        ack_pulse();
        expect_win(700, 1, 1, 0);
        wait_win(0);

        // enable dropped for 200 cycles mid-window; ack still honoured
        wait_win(300);
        enable = 1'b0;
        repeat (100) @(negedge clk);
        ack_pulse();
        repeat (99) @(negedge clk);
        check("gated_duty",    int'(duty_cycle), 700);
        check("gated_valid",   int'(duty_valid), 0);
        check("gated_overrun", int'(overrun),    0);
        enable = 1'b1;
        wait_win(0);
        ack_pulse();
        expect_win(700, 1, 1, 0);
        wait_win(0);
        @(negedge clk);

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
